// File: rtl/mem_controller_arb.sv
// Round-robin arbiter feeding one memory bus: lane-steered writes, extended reads, misalign/timeout errors.
// Grant is combinational in IDLE; writes complete 2 cycles after grant and reads 3, with stalls while MEM_Ready/MEM_DataReady are low.
module mem_controller_arb #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_PORTS-1:0]     Execute,
    input  logic [N_PORTS-1:0]     DataWe,
    input  logic [N_PORTS*ADDR_W-1:0] Address,
    input  logic [N_PORTS*32-1:0]  InData,
    input  logic [N_PORTS*2-1:0]   DataByteEn,
    input  logic [N_PORTS-1:0]     SignExtend,
    output logic [N_PORTS-1:0]     Ready,
    output logic [N_PORTS-1:0]     Grant,
    output logic [N_PORTS-1:0]     DataReady,
    output logic [N_PORTS-1:0]     Err,
    output logic [31:0]            OutData,
    input  logic                   MEM_Ready,
    output logic                   MEM_Cmd,
    output logic                   MEM_We,
    output logic [1:0]             MEM_ByteEnable,
    output logic [ADDR_W-1:0]      MEM_Addr,
    output logic [31:0]            MEM_OutData,
    input  logic [31:0]            MEM_InData,
    input  logic                   MEM_DataReady
);
    localparam int PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int IW    = PW + 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [PW-1:0]    LAST   = PW'(N_PORTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               state_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [PW-1:0]        owner_q;
    logic [CNT_W-1:0]     wd_q;
    logic                 sext_q;
    logic                 mem_cmd_q;
    logic                 mem_we_q;
    logic [1:0]           mem_be_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [31:0]          mem_wdat_q;
    logic [N_PORTS-1:0]   dready_q;
    logic [N_PORTS-1:0]   err_q;
    logic [31:0]          out_q;

    logic                 found;
    logic [PW-1:0]        win_idx;
    logic [IW-1:0]        cand;
    logic [N_PORTS-1:0]   grant_vec;
    logic [N_PORTS-1:0]   owner_oh;
    logic                 sel_we;
    logic                 sel_sext;
    logic [1:0]           sel_size;
    logic [ADDR_W-1:0]    sel_addr;
    logic [31:0]          sel_data;
    logic                 misaligned;
    logic [31:0]          wdat_d;
    logic [31:0]          shifted;
    logic [31:0]          rdat_d;
    logic                 wd_hit;

    // Search starts at rr_ptr and wraps, so a port that just finished goes to the back.
    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        cand      = '0;
        grant_vec = '0;
        if (state_q == S_IDLE && !Reset) begin
            for (int k = 0; k < N_PORTS; k++) begin
                cand = {1'b0, rr_ptr_q} + IW'(k);
                if (cand >= IW'(N_PORTS)) begin
                    cand = cand - IW'(N_PORTS);
                end
                if (!found && Execute[cand[PW-1:0]]) begin
                    found   = 1'b1;
                    win_idx = cand[PW-1:0];
                end
            end
        end
        for (int i = 0; i < N_PORTS; i++) begin
            grant_vec[i] = found && (win_idx == PW'(i));
        end
    end

    always_comb begin
        sel_we   = 1'b0;
        sel_sext = 1'b0;
        sel_size = '0;
        sel_addr = '0;
        sel_data = '0;
        owner_oh = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_vec[i]) begin
                sel_we   = DataWe[i];
                sel_sext = SignExtend[i];
                sel_size = DataByteEn[i*2 +: 2];
                sel_addr = Address[i*ADDR_W +: ADDR_W];
                sel_data = InData[i*32 +: 32];
            end
            owner_oh[i] = (owner_q == PW'(i));
        end
    end

    assign misaligned = ((sel_size == 2'b01) && sel_addr[0]) ||
                        (sel_size[1] && (sel_addr[1:0] != 2'b00));

    always_comb begin
        case (sel_size)
            2'b00:   wdat_d = {4{sel_data[7:0]}};
            2'b01:   wdat_d = {2{sel_data[15:0]}};
            default: wdat_d = sel_data;
        endcase
    end

    assign shifted = MEM_InData >> {mem_addr_q[1:0], 3'b000};

    always_comb begin
        case (mem_be_q)
            2'b00:   rdat_d = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            2'b01:   rdat_d = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            default: rdat_d = MEM_InData;
        endcase
    end

    // Timeout wins over a same-cycle MEM_Ready/MEM_DataReady.
    assign wd_hit = (TIMEOUT > 0) && (wd_q == TO_VAL);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            wd_q       <= '0;
            sext_q     <= 1'b0;
            mem_cmd_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= '0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
            dready_q   <= '0;
            err_q      <= '0;
            out_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        owner_q    <= win_idx;
                        mem_we_q   <= sel_we;
                        mem_be_q   <= sel_size;
                        mem_addr_q <= sel_addr;
                        mem_wdat_q <= wdat_d;
                        sext_q     <= sel_sext;
                        wd_q       <= '0;
                        if (misaligned) begin
                            state_q  <= S_RESP;
                            dready_q <= grant_vec;
                            err_q    <= grant_vec;
                        end else begin
                            state_q   <= S_ISSUE;
                            mem_cmd_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (TIMEOUT > 0) begin
                        wd_q <= wd_q + CNT_W'(1);
                    end
                    if (wd_hit) begin
                        state_q   <= S_RESP;
                        mem_cmd_q <= 1'b0;
                        dready_q  <= owner_oh;
                        err_q     <= owner_oh;
                    end else if (state_q == S_ISSUE) begin
                        if (MEM_Ready) begin
                            mem_cmd_q <= 1'b0;
                            if (mem_we_q) begin
                                state_q  <= S_RESP;
                                dready_q <= owner_oh;
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end
                    end else if (MEM_DataReady) begin
                        out_q    <= rdat_d;
                        state_q  <= S_RESP;
                        dready_q <= owner_oh;
                    end
                end
                S_RESP: begin
                    dready_q <= '0;
                    err_q    <= '0;
                    rr_ptr_q <= (owner_q == LAST) ? '0 : owner_q + PW'(1);
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Ready          = {N_PORTS{(state_q == S_IDLE) && !Reset}};
    assign Grant          = grant_vec;
    assign DataReady      = dready_q;
    assign Err            = err_q;
    assign OutData        = out_q;
    assign MEM_Cmd        = mem_cmd_q;
    assign MEM_We         = mem_we_q;
    assign MEM_ByteEnable = mem_be_q;
    assign MEM_Addr       = mem_addr_q;
    assign MEM_OutData    = mem_wdat_q;
endmodule

// File: tb/tb_mem_controller_arb.sv
// Directed and randomized checks of mem_controller_arb against a transaction-level reference model.
module tb_mem_controller_arb;
    localparam int N  = 2;
    localparam int TO = 4;

    logic          Clk;
    logic          Reset;
    logic [N-1:0]  Execute, DataWe, SignExtend;
    logic [N*32-1:0] Address, InData;
    logic [N*2-1:0]  DataByteEn;
    logic [N-1:0]  Ready, Grant, DataReady, Err;
    logic [31:0]   OutData;
    logic          MEM_Ready, MEM_Cmd, MEM_We, MEM_DataReady;
    logic [1:0]    MEM_ByteEnable;
    logic [31:0]   MEM_Addr, MEM_OutData, MEM_InData;

    mem_controller_arb #(.N_PORTS(N), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .Execute(Execute), .DataWe(DataWe),
        .Address(Address), .InData(InData), .DataByteEn(DataByteEn),
        .SignExtend(SignExtend), .Ready(Ready), .Grant(Grant),
        .DataReady(DataReady), .Err(Err), .OutData(OutData),
        .MEM_Ready(MEM_Ready), .MEM_Cmd(MEM_Cmd), .MEM_We(MEM_We),
        .MEM_ByteEnable(MEM_ByteEnable), .MEM_Addr(MEM_Addr),
        .MEM_OutData(MEM_OutData), .MEM_InData(MEM_InData),
        .MEM_DataReady(MEM_DataReady)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: pending requests per port, rotation pointer, last read result.
    logic        pend [N];
    logic        r_we [N];
    logic [31:0] r_addr [N];
    logic [31:0] r_data [N];
    logic [1:0]  r_sz [N];
    logic        r_sx [N];
    int          rr_m;
    logic [31:0] out_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    task automatic smp();
        @(negedge Clk);
    endtask

    function automatic logic [31:0] steer_m(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'd0) return (d % 256) * 32'h01010101;
        if (sz == 2'd1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] rd_m(input logic [31:0] w, input logic [31:0] addr,
                                         input logic [1:0] sz, input logic sx);
        int unsigned v;
        v = w >> (8 * int'(addr % 4));
        if (sz == 2'd0) begin
            v = v % 256;
            if (sx && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (sx && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic logic mis_m(input logic [31:0] addr, input logic [1:0] sz);
        int nb;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        return (addr % nb) != 0;
    endfunction

    function automatic int pick_m();
        for (int k = 0; k < N; k++) begin
            if (pend[(rr_m + k) % N]) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic post(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] sz, input logic sx);
        pend[p] = 1'b1; r_we[p] = we; r_addr[p] = addr;
        r_data[p] = data; r_sz[p] = sz; r_sx[p] = sx;
        Execute[p] = 1'b1; DataWe[p] = we; SignExtend[p] = sx;
        Address[p*32 +: 32] = addr;
        InData[p*32 +: 32] = data;
        DataByteEn[p*2 +: 2] = sz;
    endtask

    // Runs one transaction from the grant cycle: memory accepts after a cycles,
    // returns read data d cycles later (99 = never).
    task automatic serve(input int p, input int a, input int d, input logic [31:0] rword);
        int kr;
        logic er, mis;
        logic [N-1:0] oh;
        logic [31:0] exp_out;
        oh = N'(1 << p);
        mis = mis_m(r_addr[p], r_sz[p]);
        smp();
        chk("ready_idle", Ready, {N{1'b1}});
        chk("grant", Grant, oh);
        chk("cmd_idle", MEM_Cmd, 0);
        chk("dready_idle", DataReady, 0);
        nxt();
        Execute[p] = 1'b0;
        pend[p] = 1'b0;
        if (mis) begin kr = 0; er = 1'b1; end
        else if (r_we[p]) begin
            if (a < TO) begin kr = a + 1; er = 1'b0; end
            else begin kr = TO + 1; er = 1'b1; end
        end else begin
            if (a + 1 + d < TO) begin kr = a + 2 + d; er = 1'b0; end
            else begin kr = TO + 1; er = 1'b1; end
        end
        exp_out = out_m;
        if (!mis && !r_we[p] && !er) exp_out = rd_m(rword, r_addr[p], r_sz[p], r_sx[p]);
        for (int k = 0; k <= kr; k++) begin
            MEM_Ready = (k == a);
            MEM_DataReady = (k == a + 1 + d) || (k < a && $urandom_range(0, 1) == 1);
            MEM_InData = (k == a + 1 + d) ? rword : $urandom();
            smp();
            if (k < kr) begin
                chk("dready_busy", DataReady, 0);
                chk("ready_busy", Ready, 0);
                chk("cmd", MEM_Cmd, (k <= a));
                if (k == 0) begin
                    chk("maddr", MEM_Addr, r_addr[p]);
                    chk("mwe", MEM_We, r_we[p]);
                    chk("mbe", MEM_ByteEnable, r_sz[p]);
                    chk("mwdata", MEM_OutData, steer_m(r_data[p], r_sz[p]));
                end
            end else begin
                chk("dready", DataReady, oh);
                chk("err", Err, er ? oh : '0);
                chk("cmd_resp", MEM_Cmd, 0);
                chk("ready_resp", Ready, 0);
                chk("outdata", OutData, exp_out);
            end
            nxt();
        end
        MEM_Ready = 1'b0;
        MEM_DataReady = 1'b0;
        out_m = exp_out;
        rr_m = (p + 1) % N;
    endtask

    task automatic post_random(input int p);
        logic [31:0] addr;
        logic [1:0]  sz;
        addr = $urandom();
        sz = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) addr = addr & ~32'h1;
            else if (sz != 2'd0) addr = addr & ~32'h3;
        end
        post(p, 1'($urandom_range(0, 1)), addr, $urandom(), sz, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int w, a, d, mode;
        Reset = 1'b1; Execute = '1; DataWe = '0; SignExtend = '0;
        Address = '0; InData = '0; DataByteEn = '0;
        MEM_Ready = 1'b0; MEM_DataReady = 1'b0; MEM_InData = '0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        rr_m = 0; out_m = '0;
        nxt(); nxt();
        smp();
        chk("rst_ready", Ready, 0);
        chk("rst_grant", Grant, 0);
        chk("rst_cmd", MEM_Cmd, 0);
        chk("rst_we", MEM_We, 0);
        chk("rst_dready", DataReady, 0);
        chk("rst_err", Err, 0);
        chk("rst_out", OutData, 0);
        chk("rst_addr", MEM_Addr, 0);
        chk("rst_wdat", MEM_OutData, 0);
        chk("rst_be", MEM_ByteEnable, 0);
        nxt();
        Reset = 1'b0; Execute = '0;

        // Word read, sign/zero-extended byte reads, half write.
        post(0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        serve(0, 0, 0, 32'hDEADBEEF);
        smp(); chk("word_read_hold", OutData, 32'hDEADBEEF); nxt();
        post(1, 1'b0, 32'h103, 32'h0, 2'd0, 1'b1);
        serve(1, 1, 0, 32'h80FFFFFF);
        smp(); chk("byte_sext", OutData, 32'hFFFFFF80); nxt();
        post(0, 1'b0, 32'h103, 32'h0, 2'd0, 1'b0);
        serve(0, 0, 1, 32'h80FFFFFF);
        smp(); chk("byte_zext", OutData, 32'h00000080); nxt();
        post(1, 1'b1, 32'h202, 32'h1234ABCD, 2'd1, 1'b0);
        serve(1, 0, 0, 32'h0);
        smp(); chk("write_keeps_out", OutData, 32'h00000080); nxt();

        // Rotation with both ports held from rr_ptr=0, including a misaligned word.
        Reset = 1'b1; nxt(); Reset = 1'b0; rr_m = 0; out_m = '0;
        post(0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        post(1, 1'b1, 32'h300, 32'hCAFEF00D, 2'd2, 1'b0);
        serve(pick_m(), 0, 0, 32'h11223344);
        post(0, 1'b0, 32'h101, 32'h0, 2'd2, 1'b0);
        serve(pick_m(), 0, 0, 32'h0);
        post(1, 1'b1, 32'h304, 32'h55667788, 2'd0, 1'b0);
        serve(pick_m(), 0, 0, 32'h0);
        serve(pick_m(), 1, 0, 32'h0);

        // Watchdog on a never-accepted write and on a read with no data, then stray data.
        post(0, 1'b1, 32'h400, 32'h0BADBEEF, 2'd2, 1'b0);
        serve(0, 99, 0, 32'h0);
        MEM_DataReady = 1'b1; MEM_InData = 32'hA5A5A5A5; nxt(); MEM_DataReady = 1'b0;
        smp(); chk("stray_dready", DataReady, 0); chk("stray_out", OutData, out_m); nxt();
        post(1, 1'b0, 32'h404, 32'h0, 2'd2, 1'b0);
        serve(1, 0, 99, 32'h0);
        MEM_DataReady = 1'b1; nxt(); MEM_DataReady = 1'b0;
        smp(); chk("stray_dready2", DataReady, 0); chk("stray_out2", OutData, out_m); nxt();

        // Reset while waiting for read data.
        post(0, 1'b0, 32'h500, 32'h0, 2'd2, 1'b0);
        smp(); chk("rw_grant", Grant, 2'b01); nxt();
        Execute[0] = 1'b0; pend[0] = 1'b0; MEM_Ready = 1'b1;
        smp(); chk("rw_cmd", MEM_Cmd, 1); nxt();
        MEM_Ready = 1'b0;
        smp(); chk("rw_wait_cmd", MEM_Cmd, 0); chk("rw_wait_dr", DataReady, 0); nxt();
        Reset = 1'b1;
        smp(); chk("rw_rst_ready", Ready, 0); chk("rw_rst_grant", Grant, 0); nxt();
        Reset = 1'b0; MEM_DataReady = 1'b1; MEM_InData = 32'h12345678;
        smp(); chk("rw_cmd_off", MEM_Cmd, 0); chk("rw_ready", Ready, 2'b11);
        chk("rw_no_dr", DataReady, 0); nxt();
        MEM_DataReady = 1'b0;
        smp(); chk("rw_no_dr2", DataReady, 0); chk("rw_out", OutData, 0); nxt();
        rr_m = 0; out_m = '0;

        // Randomized traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            for (int q = 0; q < N; q++) begin
                if (!pend[q] && $urandom_range(0, 2) != 0) post_random(q);
            end
            if (pick_m() < 0) post_random(int'($urandom_range(0, N - 1)));
            w = pick_m();
            mode = int'($urandom_range(0, 9));
            if (mode == 0) begin a = 99; d = 0; end
            else if (mode == 1) begin a = 0; d = 99; end
            else begin
                a = int'($urandom_range(0, 2));
                d = int'($urandom_range(0, 2 - a));
            end
            serve(w, a, d, $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
